// File: rtl/uart_8n1_pkg.sv
// Shared definitions for the 8N1 UART: frame constants and FSM state encoding.
package uart_8n1_pkg;

  localparam int DATA_BITS     = 8;
  localparam int RX_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uartState_e;

endpackage

// File: rtl/uart_8n1_baud_tick_gen.sv
// Free-running dividers producing one-clk rx (oversampled) and tx baud enables.
module baud_tick_gen #(
  parameter int CLOCK_RATE    = 12000000,
  parameter int BAUD_RATE     = 9600,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rxTick_o,
  output logic txTick_o
);

  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_W   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TX_W   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

  logic [RX_W-1:0] rxCnt_q, rxCnt_d;
  logic [TX_W-1:0] txCnt_q, txCnt_d;

  always_comb begin
    rxTick_o = (rxCnt_q == RX_W'(RX_DIV - 1));
    txTick_o = (txCnt_q == TX_W'(TX_DIV - 1));
    rxCnt_d  = rxTick_o ? '0 : rxCnt_q + RX_W'(1);
    txCnt_d  = txTick_o ? '0 : txCnt_q + TX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxCnt_q <= '0;
      txCnt_q <= '0;
    end else begin
      rxCnt_q <= rxCnt_d;
      txCnt_q <= txCnt_d;
    end
  end

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART: oversampling receiver with glitch rejection and a
// tick-paced transmitter, both driven by a shared baud tick generator.
module uart_8n1 #(
  parameter int CLOCK_RATE    = 12000000,
  parameter int BAUD_RATE     = 9600,
  parameter int RX_OVERSAMPLE = uart_8n1_pkg::RX_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);
  import uart_8n1_pkg::*;

  localparam int TW         = $clog2(RX_OVERSAMPLE);
  localparam int BW         = $clog2(DATA_BITS);
  localparam int TBW        = $clog2(DATA_BITS + 1);
  localparam int START_LOWS = RX_OVERSAMPLE / 2;

  logic rxTick, txTick;

  baud_tick_gen #(
    .CLOCK_RATE   (CLOCK_RATE),
    .BAUD_RATE    (BAUD_RATE),
    .RX_OVERSAMPLE(RX_OVERSAMPLE)
  ) u_tickGen (
    .clk_i   (clk),
    .rst_i   (rst),
    .rxTick_o(rxTick),
    .txTick_o(txTick)
  );

  logic                 rxSync1_q, rxSync2_q, rxIn;
  uartState_e           rxState_q, rxState_d;
  logic [TW-1:0]        rxTickCnt_q, rxTickCnt_d;
  logic [BW-1:0]        rxBitCnt_q, rxBitCnt_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 rxBusy_q, rxBusy_d, rxDone_q, rxDone_d, rxErr_q, rxErr_d;
  logic                 rxWaitHigh_q, rxWaitHigh_d;

  assign rxIn = rxSync2_q;

  // rxWaitHigh blocks new start detection after a framing error until the line idles.
  always_comb begin
    rxState_d    = rxState_q;
    rxTickCnt_d  = rxTickCnt_q;
    rxBitCnt_d   = rxBitCnt_q;
    rxShift_d    = rxShift_q;
    out_d        = out_q;
    rxBusy_d     = rxBusy_q;
    rxDone_d     = rxDone_q;
    rxErr_d      = rxErr_q;
    rxWaitHigh_d = rxWaitHigh_q;
    if (!rxEn) begin
      rxState_d    = IDLE;
      rxTickCnt_d  = '0;
      rxBitCnt_d   = '0;
      rxBusy_d     = 1'b0;
      rxDone_d     = 1'b0;
      rxErr_d      = 1'b0;
      rxWaitHigh_d = 1'b0;
    end else if (rxTick) begin
      unique case (rxState_q)
        IDLE: begin
          if (rxWaitHigh_q) begin
            if (rxIn) rxWaitHigh_d = 1'b0;
          end else if (!rxIn) begin
            rxState_d   = START;
            rxTickCnt_d = TW'(1);
          end
        end
        START: begin
          if (rxIn) begin
            rxState_d = IDLE;
          end else if (rxTickCnt_q == TW'(START_LOWS - 1)) begin
            rxState_d   = DATA;
            rxBusy_d    = 1'b1;
            rxDone_d    = 1'b0;
            rxErr_d     = 1'b0;
            rxTickCnt_d = '0;
            rxBitCnt_d  = '0;
          end else begin
            rxTickCnt_d = rxTickCnt_q + TW'(1);
          end
        end
        DATA: begin
          if (rxTickCnt_q == TW'(RX_OVERSAMPLE - 1)) begin
            rxTickCnt_d = '0;
            rxShift_d   = {rxIn, rxShift_q[DATA_BITS-1:1]};
            rxBitCnt_d  = rxBitCnt_q + BW'(1);
            if (rxBitCnt_q == BW'(DATA_BITS - 1)) rxState_d = STOP;
          end else begin
            rxTickCnt_d = rxTickCnt_q + TW'(1);
          end
        end
        STOP: begin
          if (rxTickCnt_q == TW'(RX_OVERSAMPLE - 1)) begin
            rxTickCnt_d = '0;
            rxBusy_d    = 1'b0;
            rxState_d   = IDLE;
            if (rxIn) begin
              out_d    = rxShift_q;
              rxDone_d = 1'b1;
            end else begin
              rxErr_d      = 1'b1;
              rxWaitHigh_d = 1'b1;
            end
          end else begin
            rxTickCnt_d = rxTickCnt_q + TW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1_q    <= 1'b1;
      rxSync2_q    <= 1'b1;
      rxState_q    <= IDLE;
      rxTickCnt_q  <= '0;
      rxBitCnt_q   <= '0;
      rxShift_q    <= '0;
      out_q        <= '0;
      rxBusy_q     <= 1'b0;
      rxDone_q     <= 1'b0;
      rxErr_q      <= 1'b0;
      rxWaitHigh_q <= 1'b0;
    end else begin
      rxSync1_q    <= rx;
      rxSync2_q    <= rxSync1_q;
      rxState_q    <= rxState_d;
      rxTickCnt_q  <= rxTickCnt_d;
      rxBitCnt_q   <= rxBitCnt_d;
      rxShift_q    <= rxShift_d;
      out_q        <= out_d;
      rxBusy_q     <= rxBusy_d;
      rxDone_q     <= rxDone_d;
      rxErr_q      <= rxErr_d;
      rxWaitHigh_q <= rxWaitHigh_d;
    end
  end

  uartState_e           txState_q, txState_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic [TBW-1:0]       txBitCnt_q, txBitCnt_d;
  logic                 tx_q, tx_d, txBusy_q, txBusy_d, txDone_d, txDone_q;

  // START waits for the first tick; DATA covers the start bit and the data bits on the line.
  always_comb begin
    txState_d  = txState_q;
    txShift_d  = txShift_q;
    txBitCnt_d = txBitCnt_q;
    tx_d       = tx_q;
    txBusy_d   = txBusy_q;
    txDone_d   = 1'b0;
    unique case (txState_q)
      IDLE: begin
        tx_d = 1'b1;
        if (txEn && txStart) begin
          txShift_d = in;
          txBusy_d  = 1'b1;
          txState_d = START;
        end
      end
      START: begin
        if (txTick) begin
          tx_d       = 1'b0;
          txBitCnt_d = '0;
          txState_d  = DATA;
        end
      end
      DATA: begin
        if (txTick) begin
          if (txBitCnt_q == TBW'(DATA_BITS)) begin
            tx_d      = 1'b1;
            txState_d = STOP;
          end else begin
            tx_d       = txShift_q[0];
            txShift_d  = {1'b0, txShift_q[DATA_BITS-1:1]};
            txBitCnt_d = txBitCnt_q + TBW'(1);
          end
        end
      end
      STOP: begin
        if (txTick) begin
          txBusy_d  = 1'b0;
          txDone_d  = 1'b1;
          txState_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q  <= IDLE;
      txShift_q  <= '0;
      txBitCnt_q <= '0;
      tx_q       <= 1'b1;
      txBusy_q   <= 1'b0;
      txDone_q   <= 1'b0;
    end else begin
      txState_q  <= txState_d;
      txShift_q  <= txShift_d;
      txBitCnt_q <= txBitCnt_d;
      tx_q       <= tx_d;
      txBusy_q   <= txBusy_d;
      txDone_q   <= txDone_d;
    end
  end

  assign rxBusy = rxBusy_q;
  assign rxDone = rxDone_q;
  assign rxErr  = rxErr_q;
  assign out    = out_q;
  assign txBusy = txBusy_q;
  assign txDone = txDone_q;
  assign tx     = tx_q;

endmodule

// File: tb/tb_uart_8n1.sv
// Directed bench for uart_8n1 at default rates; rx frames use a 3% slow bit time.
module tb_uart_8n1;

  localparam int BIT_CLKS = 1290;

  logic       clk = 1'b0;
  logic       rst, rxEn, rx, txEn, txStart;
  logic [7:0] in;
  logic       rxBusy, rxDone, rxErr, txBusy, txDone, tx;
  logic [7:0] out;

  int   testsRun = 0;
  int   testsFailed = 0;
  logic clrMon;
  logic sawBusy;
  int   txDoneCount;

  uart_8n1 dut (
    .clk    (clk),
    .rst    (rst),
    .rxEn   (rxEn),
    .rx     (rx),
    .rxBusy (rxBusy),
    .rxDone (rxDone),
    .rxErr  (rxErr),
    .out    (out),
    .txEn   (txEn),
    .txStart(txStart),
    .in     (in),
    .txBusy (txBusy),
    .txDone (txDone),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  // Sticky monitors so short rxBusy/txDone activity between checks is not missed.
  always @(posedge clk) begin
    if (clrMon) begin
      sawBusy     <= 1'b0;
      txDoneCount <= 0;
    end else begin
      if (rxBusy) sawBusy <= 1'b1;
      if (txDone) txDoneCount <= txDoneCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic holdClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearMonitors();
    clrMon = 1'b1;
    @(negedge clk);
    clrMon = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int bit7Clks, input int stopClks,
                               input logic stopLevel, input logic expBusy, input logic expDone);
    rx = 1'b0;
    holdClks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == 3) begin
        holdClks(BIT_CLKS / 2);
        checkOutput("rxBusy mid-frame", rxBusy, expBusy);
        checkOutput("rxDone mid-frame", rxDone, expDone);
        holdClks(BIT_CLKS - BIT_CLKS / 2);
      end else begin
        holdClks((i == 7) ? bit7Clks : BIT_CLKS);
      end
    end
    rx = stopLevel;
    holdClks(stopClks);
  endtask

  task automatic txSequence();
    logic [9:0] txSeq;
    int         waitCnt;
    txSeq   = 10'b1101001010;
    waitCnt = 0;
    txEn    = 1'b1;
    in      = 8'hA5;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    checkOutput("txBusy after start", txBusy, 1'b1);
    while (tx !== 1'b0 && waitCnt < 1300) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("tx start bit within one tick", waitCnt < 1300, 1'b1);
    for (int k = 0; k <= 12501; k++) begin
      if (k == 3000) begin
        txStart = 1'b1;
        in      = 8'hFF;
      end
      if (k == 3001) begin
        txStart = 1'b0;
        in      = 8'hA5;
      end
      if (k % 1250 == 625 && k < 12500) begin
        checkOutput("tx bit value", tx, txSeq[k / 1250]);
        checkOutput("txBusy in frame", txBusy, 1'b1);
      end
      if (k == 1249) checkOutput("tx start bit last clk", tx, 1'b0);
      if (k == 1250) checkOutput("tx bit0 first clk", tx, 1'b1);
      if (k == 12499) begin
        checkOutput("txBusy before end", txBusy, 1'b1);
        checkOutput("txDone before end", txDone, 1'b0);
      end
      if (k == 12500) begin
        checkOutput("txDone at end", txDone, 1'b1);
        checkOutput("txBusy at end", txBusy, 1'b0);
        checkOutput("tx idle at end", tx, 1'b1);
      end
      if (k == 12501) checkOutput("txDone one clk", txDone, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst     = 1'b1;
    rxEn    = 1'b0;
    rx      = 1'b1;
    txEn    = 1'b0;
    txStart = 1'b0;
    in      = 8'h00;
    clrMon  = 1'b0;
    holdClks(3);
    checkOutput("reset out", out, 8'h00);
    checkOutput("reset rxBusy", rxBusy, 1'b0);
    checkOutput("reset rxDone", rxDone, 1'b0);
    checkOutput("reset rxErr", rxErr, 1'b0);
    checkOutput("reset tx", tx, 1'b1);
    checkOutput("reset txBusy", txBusy, 1'b0);
    checkOutput("reset txDone", txDone, 1'b0);

    rst  = 1'b0;
    rxEn = 1'b1;
    clearMonitors();
    holdClks(200);
    rx = 1'b0;
    holdClks(192);
    rx = 1'b1;
    holdClks(1500);
    checkOutput("glitch no busy", sawBusy, 1'b0);
    checkOutput("glitch no done", rxDone, 1'b0);
    checkOutput("glitch no err", rxErr, 1'b0);

    clearMonitors();
    fork
      applyStimulus(8'h56, BIT_CLKS, BIT_CLKS, 1'b1, 1'b1, 1'b0);
      txSequence();
    join
    checkOutput("frame1 out", out, 8'h56);
    checkOutput("frame1 rxDone", rxDone, 1'b1);
    checkOutput("frame1 rxErr", rxErr, 1'b0);
    checkOutput("frame1 saw busy", sawBusy, 1'b1);
    checkOutput("frame1 busy cleared", rxBusy, 1'b0);
    checkOutput("single txDone pulse", txDoneCount, 1);

    applyStimulus(8'h56, 720, 1860, 1'b1, 1'b1, 1'b0);
    checkOutput("short bit7 out", out, 8'h56);
    checkOutput("short bit7 rxDone", rxDone, 1'b1);
    applyStimulus(8'h56, BIT_CLKS, BIT_CLKS, 1'b1, 1'b1, 1'b0);
    checkOutput("back-to-back out", out, 8'h56);
    checkOutput("back-to-back rxDone", rxDone, 1'b1);
    checkOutput("back-to-back rxErr", rxErr, 1'b0);

    applyStimulus(8'h3C, BIT_CLKS, BIT_CLKS, 1'b0, 1'b1, 1'b0);
    clearMonitors();
    holdClks(1200);
    checkOutput("framing rxErr", rxErr, 1'b1);
    checkOutput("framing rxDone", rxDone, 1'b0);
    checkOutput("framing out kept", out, 8'h56);
    checkOutput("no frame while low", sawBusy, 1'b0);
    rx = 1'b1;
    holdClks(600);
    checkOutput("rxErr holds", rxErr, 1'b1);

    rxEn = 1'b0;
    holdClks(5);
    checkOutput("rxEn off clears rxErr", rxErr, 1'b0);
    clearMonitors();
    applyStimulus(8'hA5, BIT_CLKS, BIT_CLKS, 1'b1, 1'b0, 1'b0);
    holdClks(300);
    checkOutput("disabled no busy", sawBusy, 1'b0);
    checkOutput("disabled no done", rxDone, 1'b0);
    checkOutput("disabled no err", rxErr, 1'b0);
    checkOutput("disabled out kept", out, 8'h56);

    rxEn = 1'b1;
    holdClks(200);
    txEn    = 1'b1;
    in      = 8'h0F;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    rx      = 1'b0;
    holdClks(BIT_CLKS * 3);
    checkOutput("rxBusy before reset", rxBusy, 1'b1);
    checkOutput("txBusy before reset", txBusy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset out", out, 8'h00);
    checkOutput("mid reset rxBusy", rxBusy, 1'b0);
    checkOutput("mid reset rxDone", rxDone, 1'b0);
    checkOutput("mid reset rxErr", rxErr, 1'b0);
    checkOutput("mid reset tx", tx, 1'b1);
    checkOutput("mid reset txBusy", txBusy, 1'b0);
    checkOutput("mid reset txDone", txDone, 1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    holdClks(2000);
    checkOutput("post reset rxBusy", rxBusy, 1'b0);
    checkOutput("post reset tx idle", tx, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_8n1.md
Name: uart_8n1

Overview:
Full-duplex 8N1 UART core: 8 data bits, no parity, 1 stop bit, LSB first. It contains a receiver, a transmitter and a shared baud-tick generator. The core sits between an off-chip serial line and on-chip byte-level logic. Both directions use simple enable/start/busy/done handshakes.

Parameters:
CLOCK_RATE, 12000000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bit/s.
RX_OVERSAMPLE, 16, receive ticks per bit period.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
rxEn  in  1  receiver enable.
rx  in  1  serial input; idles high.
rxBusy  out  1  frame in progress (start bit validated, through the stop bit).
rxDone  out  1  last frame received correctly; `out` is valid.
rxErr  out  1  last frame had a framing error.
out  out  8  received byte.
txEn  in  1  transmitter enable.
txStart  in  1  request to send `in`.
in  in  8  byte to transmit.
txBusy  out  1  transmission in progress.
txDone  out  1  one-clk pulse when the stop bit completes.
tx  out  1  serial output; idles high.

Behaviour:
- Reset (synchronous, rst=1 on a clk edge):
  - out=0, rxBusy=0, rxDone=0, rxErr=0.
  - tx=1, txBusy=0, txDone=0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame silently.
- Baud ticks are one-clk enable pulses, not derived clocks:
  - rxTick every CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE) clks, integer-truncated (78 at the defaults).
  - txTick every CLOCK_RATE/BAUD_RATE clks (1250 at the defaults).
  - The counters free-run.
- rx is passed through a 2-flop synchroniser before use.
- Receiver FSM (advances only on rxTick):
  - IDLE:
    - Entered when rxEn=0, and held there while rxEn=0.
    - When rxEn=1 and sampled rx=0, go to START with sample count 1.
  - START:
    - Counts consecutive low samples.
    - If rx=1 before 8 lows, the glitch is rejected: return to IDLE with no flag change.
    - On the 8th low (mid start bit): set rxBusy=1, clear rxDone and rxErr, reset the tick count, go to DATA.
  - DATA:
    - Every 16 ticks (mid-bit), shift the sampled rx into the shift register, LSB first.
    - After 8 bits, go to STOP.
  - STOP:
    - After 16 ticks, sample rx and clear rxBusy.
    - If rx=1: out=shift register, rxDone=1.
    - If rx=0: rxErr=1, out unchanged, and the FSM stays in IDLE-wait until rx returns high.
    - Return to IDLE.
- Receiver tolerance: mid-bit sampling must absorb ±3% baud mismatch across one frame.
- rxDone and rxErr are levels. They hold until the next validated start bit, rxEn=0, or reset.
- Back-to-back frames: a start bit that immediately follows a valid stop bit must be captured.
- Transmitter FSM:
  - IDLE: on txEn=1 and txStart=1, latch `in`, set txBusy=1.
  - On the next txTick drive tx=0 (start bit).
  - Then send 8 data bits LSB first, one per txTick.
  - Then tx=1 for one txTick (stop bit).
  - At the end of the stop bit: txBusy=0, txDone pulses for 1 clk, return to IDLE.
  - txStart while busy is ignored.
  - txEn=0 while busy finishes the current frame.
- Simultaneous rx/tx operation is fully independent.

Decomposition:
- Shared package: state encodings (IDLE/START/DATA/STOP for both FSMs) and the constants DATA_BITS=8 and RX_OVERSAMPLE.
- One sub-module, baud_tick_gen(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE), producing the rxTick and txTick enables.
- Receiver and transmitter stay inline or in separate always blocks.

Test Plan:
- Reset, then rxEn=1 with rx pulsed low for 16 µs (about 2.5 rxTicks) → rejected; rxBusy stays 0, no flags.
- Receive 0x56 with a 107.5 µs bit time (3% slow) → rxBusy during the frame; out=0x56, rxDone=1, rxErr=0 after the stop sample.
- Same frame but bit 7 shortened to about 60 µs, then a 155 µs stop bit, then a second 0x56 frame → both captured; rxDone clears at the second validated start bit.
- Frame with the stop bit held 0 → rxErr=1, rxDone=0, out keeps its previous value; no new frame accepted until rx returns high.
- rxEn=0 during a valid frame → nothing captured and all rx flags stay 0. Assert rst mid-frame → outputs return to reset values on the next clk.
- txEn=1, txStart pulse with in=0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 1250 clks; txBusy high throughout; one-clk txDone at the end; a txStart mid-frame is ignored.
